// File: rtl/usr_stepped_param.sv
// usr_stepped_param
//   Universal shift register of WIDTH bits, advanced one operation per press
//   of a raw (bouncy, asynchronous) switch. The switch only ever feeds an
//   enable: it is synchronised, debounced and rising-edge detected into a
//   one-cycle STEP_PULSE on CLK. STEP_COUNT counts accepted steps for
//   board-level debug.
//
// Ports
//   CLK             system clock, rising edge
//   RST             synchronous active-high reset, highest priority
//   SWITCH          raw step switch
//   CLR             synchronous register clear, acts without a step
//   MODE[2:0]       operation applied on a step
//                   000 hold, 001 shr, 010 shl, 011 load, 100 ror,
//                   101 rol, 110 asr, 111 hold
//   SERIAL_IN_R     bit entering the MSB on shift right
//   SERIAL_IN_L     bit entering the LSB on shift left
//   PARALLEL_INPUT  load data
//   PARALLEL_OUT    register contents (bit WIDTH-1 is the MSB)
//   SERIAL_OUT_R    PARALLEL_OUT[0]
//   SERIAL_OUT_L    PARALLEL_OUT[WIDTH-1]
//   STEP_PULSE      one-cycle pulse per accepted press
//   STEP_COUNT      accepted steps, wraps modulo 2^COUNT_WIDTH
module usr_stepped_param #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SWITCH,
  input  logic                   CLR,
  input  logic [2:0]             MODE,
  input  logic                   SERIAL_IN_R,
  input  logic                   SERIAL_IN_L,
  input  logic [WIDTH-1:0]       PARALLEL_INPUT,
  output logic [WIDTH-1:0]       PARALLEL_OUT,
  output logic                   SERIAL_OUT_R,
  output logic                   SERIAL_OUT_L,
  output logic                   STEP_PULSE,
  output logic [COUNT_WIDTH-1:0] STEP_COUNT
);

  // +1 keeps the width non-zero when DEBOUNCE_CYCLES is 1.
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             sw_sync_p0;
  logic             sw_sync_p1;
  logic [DB_W-1:0]  db_cnt_p2;
  logic             stable_p2;
  logic             stable_d_p3;
  logic [WIDTH-1:0] shift_reg;

  // Next register value for one step of the selected operation.
  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sin_r,
    input logic             sin_l,
    input logic [WIDTH-1:0] load
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      3'b001:  nxt = {sin_r, cur[WIDTH-1:1]};
      3'b010:  nxt = {cur[WIDTH-2:0], sin_l};
      3'b011:  nxt = load;
      3'b100:  nxt = {cur[0], cur[WIDTH-1:1]};
      3'b101:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b110:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous switch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_sync_p0 <= 1'b0;
      sw_sync_p1 <= 1'b0;
    end else begin
      sw_sync_p0 <= SWITCH;
      sw_sync_p1 <= sw_sync_p0;
    end
  end

  // Stage p2: debouncer. The level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_cnt_p2 <= '0;
      stable_p2 <= 1'b0;
    end else if (sw_sync_p1 != stable_p2) begin
      if (db_cnt_p2 == DB_LAST) begin
        stable_p2 <= sw_sync_p1;
        db_cnt_p2 <= '0;
      end else begin
        db_cnt_p2 <= db_cnt_p2 + 1'b1;
      end
    end else begin
      db_cnt_p2 <= '0;
    end
  end

  // Stage p3: rising-edge detect of the debounced level; releases never pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stable_d_p3 <= 1'b0;
      STEP_PULSE  <= 1'b0;
    end else begin
      stable_d_p3 <= stable_p2;
      STEP_PULSE  <= stable_p2 & ~stable_d_p3;
    end
  end

  // Stage p4: step counter and register. A step swallowed by CLR still counts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      STEP_COUNT <= '0;
      shift_reg  <= '0;
    end else begin
      if (STEP_PULSE) begin
        STEP_COUNT <= STEP_COUNT + 1'b1;
      end
      if (CLR) begin
        shift_reg <= '0;
      end else if (STEP_PULSE) begin
        shift_reg <= step_op(MODE, shift_reg, SERIAL_IN_R, SERIAL_IN_L, PARALLEL_INPUT);
      end
    end
  end

  assign PARALLEL_OUT = shift_reg;
  assign SERIAL_OUT_R = shift_reg[0];
  assign SERIAL_OUT_L = shift_reg[WIDTH-1];

endmodule

// File: tb/tb_usr_stepped_param.sv
// Testbench for usr_stepped_param (WIDTH=4, DEBOUNCE_CYCLES=4, COUNT_WIDTH=8).
// A reference model advanced once per clock edge predicts STEP_PULSE,
// STEP_COUNT and the register; directed sequences add fixed expectations.
module tb_usr_stepped_param;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, sw, clr, sir, sil;
  logic [2:0]    mode;
  logic [W-1:0]  pin;
  logic [W-1:0]  pout;
  logic          sout_r, sout_l, pulse;
  logic [CW-1:0] cnt;

  usr_stepped_param #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CW)) dut (
    .CLK(clk), .RST(rst), .SWITCH(sw), .CLR(clr), .MODE(mode),
    .SERIAL_IN_R(sir), .SERIAL_IN_L(sil), .PARALLEL_INPUT(pin),
    .PARALLEL_OUT(pout), .SERIAL_OUT_R(sout_r), .SERIAL_OUT_L(sout_l),
    .STEP_PULSE(pulse), .STEP_COUNT(cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int m_reg, m_cnt;
  bit m_pulse, m_stab, m_rose;
  bit hist [0:D];      // hist[i] = switch level sampled i+1 edges ago
  int dut_pulses;

  // Values applied on the edge that consumes a step; junk elsewhere
  logic [2:0]   want_mode;
  logic         want_sir, want_sil, want_clr;
  logic [W-1:0] want_pin;
  bit           junk_en;

  function automatic int ref_op(input int op, input int r, input int si_r,
                                input int si_l, input int ld);
    int mask = (1 << W) - 1;
    case (op)
      1:       return (r >> 1) | (si_r << (W - 1));
      2:       return ((r << 1) | si_l) & mask;
      3:       return ld;
      4:       return (r >> 1) | ((r & 1) << (W - 1));
      5:       return ((r << 1) | (r >> (W - 1))) & mask;
      6:       return (r >> 1) | (r & (1 << (W - 1)));
      default: return r;
    endcase
  endfunction

  // One clock edge of the specified behaviour. The debounced level flips
  // once the synchronised input (two edges old) has shown the opposite level
  // for D consecutive edges; a pulse follows one edge after a rising flip.
  task automatic model_step();
    bit all_opp;
    bit next_pulse;
    if (rst) begin
      m_reg = 0; m_cnt = 0; m_pulse = 0; m_stab = 0; m_rose = 0;
      for (int i = 0; i <= D; i++) hist[i] = 0;
    end else begin
      if (clr) m_reg = 0;
      else if (m_pulse) m_reg = ref_op(int'(mode), m_reg, int'(sir), int'(sil), int'(pin));
      if (m_pulse) m_cnt = (m_cnt + 1) % (1 << CW);
      next_pulse = m_rose;
      all_opp = 1;
      for (int i = 1; i <= D; i++) if (hist[i] == m_stab) all_opp = 0;
      m_rose = 0;
      if (all_opp) begin
        m_stab = !m_stab;
        m_rose = m_stab;
      end
      m_pulse = next_pulse;
      for (int i = D; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = sw;
    end
  endtask

  task automatic tick();
    if (m_pulse) begin
      mode = want_mode; sir = want_sir; sil = want_sil; pin = want_pin; clr = want_clr;
    end else begin
      clr = 1'b0;
      if (junk_en) begin
        mode = 3'($urandom); sir = 1'($urandom); sil = 1'($urandom); pin = W'($urandom);
      end
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("step_pulse",   32'(pulse),  32'(m_pulse));
    chk("parallel_out", 32'(pout),   32'(m_reg));
    chk("step_count",   32'(cnt),    32'(m_cnt));
    chk("serial_out_r", 32'(sout_r), 32'(m_reg & 1));
    chk("serial_out_l", 32'(sout_l), 32'((m_reg >> (W - 1)) & 1));
    if (pulse === 1'b1) dut_pulses++;
  endtask

  // One press: optional 1-cycle bounces, a long hold, a release with
  // 2-cycle bounces, then quiet. Reports DUT pulses seen during it.
  task automatic press(input int bounce, output int npulse);
    int start;
    start = dut_pulses;
    for (int i = 0; i < bounce; i++) begin
      sw = (i % 2 == 0);
      tick();
    end
    sw = 1'b1;
    for (int i = 0; i < D + 8; i++) tick();
    sw = 1'b0; tick(); tick();
    sw = 1'b1; tick(); tick();
    sw = 1'b0;
    for (int i = 0; i < D + 6; i++) tick();
    npulse = dut_pulses - start;
  endtask

  task automatic step(input logic [2:0] m, input logic [W-1:0] p,
                      input logic r, input logic l, input logic c);
    int n;
    want_mode = m; want_pin = p; want_sir = r; want_sil = l; want_clr = c;
    press(0, n);
    chk("press_pulses", 32'(n), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, n, c0;
    rst = 1'b1; sw = 1'b1; clr = 1'b0; mode = 3'd0; sir = 1'b0; sil = 1'b0; pin = '0;
    want_mode = 3'd0; want_pin = '0; want_sir = 1'b0; want_sil = 1'b0; want_clr = 1'b0;
    junk_en = 0; dut_pulses = 0;
    m_reg = 0; m_cnt = 0; m_pulse = 0; m_stab = 0; m_rose = 0;
    for (int i = 0; i <= D; i++) hist[i] = 0;
    @(negedge clk);

    // Reset with switch held high
    tick(); tick();
    chk("rst_pout",  32'(pout),  32'd0);
    chk("rst_count", 32'(cnt),   32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    rst = 1'b0;
    first = -1;
    dut_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse === 1'b1 && first < 0) first = i;
    end
    // first edge after release is edge 0; the pulse is consumed D+3 edges later
    chk("rst_pulse_latency", 32'(first + 1), 32'(D + 3));
    chk("rst_pulse_once",    32'(dut_pulses), 32'd1);
    sw = 1'b0;
    for (int i = 0; i < D + 6; i++) tick();

    // Reset in the middle of a debounce, switch stays high
    dut_pulses = 0;
    sw = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; tick();
    chk("midrst_pulse", 32'(dut_pulses), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < D + 8; i++) tick();
    chk("midrst_once", 32'(dut_pulses), 32'd1);
    sw = 1'b0;
    for (int i = 0; i < D + 6; i++) tick();

    // Bounce rejection: 1,0,1,0,1 then hold
    press(5, n);
    chk("bounce_once", 32'(n), 32'd1);

    // Load and shifts, with junk on the data pins away from the step
    junk_en = 1;
    step(3'b011, 4'b1011, 1'b0, 1'b0, 1'b0); chk("load_1011", 32'(pout), 32'b1011);
    step(3'b001, 4'b0000, 1'b0, 1'b0, 1'b0); chk("shr_0101",  32'(pout), 32'b0101);
    step(3'b010, 4'b0000, 1'b0, 1'b1, 1'b0); chk("shl_1011",  32'(pout), 32'b1011);

    // Rotates and arithmetic shift
    step(3'b011, 4'b1001, 1'b0, 1'b0, 1'b0); chk("load_1001", 32'(pout), 32'b1001);
    step(3'b100, 4'b0000, 1'b1, 1'b1, 1'b0); chk("ror_1100",  32'(pout), 32'b1100);
    step(3'b101, 4'b0000, 1'b0, 1'b0, 1'b0); chk("rol_1001",  32'(pout), 32'b1001);
    step(3'b110, 4'b0000, 1'b0, 1'b0, 1'b0); chk("asr_1100",  32'(pout), 32'b1100);
    step(3'b110, 4'b0000, 1'b0, 1'b0, 1'b0); chk("asr_1110",  32'(pout), 32'b1110);
    step(3'b111, 4'b0101, 1'b1, 1'b1, 1'b0); chk("rsv_hold",  32'(pout), 32'b1110);

    // CLR on the step edge wins over a load; the step still counts
    step(3'b011, 4'b1111, 1'b0, 1'b0, 1'b0); chk("load_1111", 32'(pout), 32'b1111);
    c0 = int'(cnt);
    step(3'b011, 4'b0110, 1'b0, 1'b0, 1'b1);
    chk("clr_pout",  32'(pout), 32'd0);
    chk("clr_count", 32'(cnt),  32'((c0 + 1) % 256));

    // 256 hold steps wrap the counter back to where it started
    step(3'b011, 4'b1010, 1'b0, 1'b0, 1'b0);
    c0 = int'(cnt);
    dut_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      want_mode = 3'b000; want_clr = 1'b0;
      press(0, n);
    end
    chk("wrap_pulses", 32'(dut_pulses), 32'd256);
    chk("wrap_count",  32'(cnt),  32'(c0));
    chk("wrap_pout",   32'(pout), 32'b1010);

    // Randomised steps against the model
    for (int i = 0; i < 24; i++) begin
      want_mode = 3'($urandom); want_pin = W'($urandom);
      want_sir = 1'($urandom); want_sil = 1'($urandom);
      want_clr = ($urandom_range(7, 0) == 0);
      press(int'($urandom_range(5, 0)), n);
      chk("rand_press", 32'(n), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
